// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, line levels and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

    // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic par(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Divide-by-CLKS_PER_BIT bit-timing counter; Tick marks each bit boundary.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic Clear,
    input  logic Enable,
    output logic Tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LastCnt = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    // Tick ignores Clear so the framer can accept on the same edge a stop bit ends.
    assign Tick = Enable && (cnt_q == LastCnt);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q <= '0;
        end else if (Clear) begin
            cnt_q <= '0;
        end else if (Enable) begin
            cnt_q <= (cnt_q == LastCnt) ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, LSB-first data, optional parity, 1-2 stop bits.
// Parity stage is built only when UART_TX_PARITY_EN is defined.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic [DATA_W-1:0] Din,
    input  logic              Valid,
    output logic              Ready,
    output logic              SerOut,
    output logic              Busy
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LastData = BW'(DATA_W - 1);
    localparam logic [BW-1:0] LastStop = BW'(STOP_BITS - 1);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              ser_q, ser_d;
    logic              tick, last_stop, accept;

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .Clock  (Clock),
        .Reset_n(Reset_n),
        .Clear  (accept),
        .Enable (state_q != IDLE),
        .Tick   (tick)
    );

`ifdef UART_TX_PARITY_EN
    logic par_q;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= par(9'(Din), PARITY_ODD != 0);
        end
    end
`endif

    // Ready is raised through the final stop-bit cycle so a held Valid chains frames
    // with no idle gap.
    assign last_stop = (state_q == STOP) && (bit_cnt_q == LastStop) && tick;
    assign Ready     = (state_q == IDLE) || last_stop;
    assign Busy      = !Ready;
    assign accept    = Valid && Ready;
    assign SerOut    = ser_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        ser_d     = ser_q;
        case (state_q)
            IDLE: ;
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    ser_d     = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LastData) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
                        ser_d     = par_q;
`else
                        state_d   = STOP;
                        ser_d     = UART_IDLE_LEVEL;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        ser_d     = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                    ser_d     = UART_IDLE_LEVEL;
                end
            end
`endif
            STOP: begin
                if (last_stop) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else if (tick) begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ser_d   = UART_IDLE_LEVEL;
            end
        endcase
        if (accept) begin
            state_d   = START;
            shift_d   = Din;
            bit_cnt_d = '0;
            ser_d     = UART_START_LEVEL;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            ser_q     <= UART_IDLE_LEVEL;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            ser_q     <= ser_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: one 1-stop/even instance and one 2-stop/odd instance.
module tb_uart_tx_framer;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] din   [2];
    logic       valid [2];
    logic       rdy   [2];
    logic       ser   [2];
    logic       bsy   [2];

    int checks = 0;
    int fails  = 0;

    uart_tx_framer #(
        .DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)
    ) u_dut0 (
        .Clock(clk), .Reset_n(rst_n), .Din(din[0]), .Valid(valid[0]),
        .Ready(rdy[0]), .SerOut(ser[0]), .Busy(bsy[0])
    );

    uart_tx_framer #(
        .DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(1)
    ) u_dut1 (
        .Clock(clk), .Reset_n(rst_n), .Din(din[1]), .Valid(valid[1]),
        .Ready(rdy[1]), .SerOut(ser[1]), .Busy(bsy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input int i, input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (P == 1 && b == 9) return (^d) ^ (i == 1);
        return 1'b1;
    endfunction

    // Present a word and step past the accepting edge.
    task automatic start(input int i, input logic [7:0] d);
        @(negedge clk);
        din[i]   = d;
        valid[i] = 1'b1;
        chk("ready_before_accept", 32'(rdy[i]), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Called just after the accepting edge; checks every cycle of the frame.
    task automatic frame(input int i, input logic [7:0] d, input logic keep,
                         input logic [7:0] nd, input logic pulse);
        int sb = (i == 0) ? 1 : 2;
        int f  = (1 + 8 + P + sb) * CPB;
        din[i] = nd;
        if (!keep) valid[i] = 1'b0;
        for (int k = 0; k < f; k++) begin
            @(negedge clk);
            if (pulse) valid[i] = (k >= 10 && k < 14);
            chk("serout", 32'(ser[i]), 32'(exp_bit(i, d, k / CPB)));
            chk("ready", 32'(rdy[i]), 32'(k == f - 1));
            chk("busy", 32'(bsy[i]), 32'(k != f - 1));
        end
    endtask

    task automatic idle_check(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("idle_serout", 32'(ser[i]), 32'd1);
            chk("idle_ready", 32'(rdy[i]), 32'd1);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        din[0]   = '0;
        din[1]   = '0;
        valid[0] = 1'b0;
        valid[1] = 1'b0;

        // Reset and idle after release
        repeat (3) @(negedge clk);
        chk("reset_serout", 32'(ser[0]), 32'd1);
        chk("reset_ready", 32'(rdy[0]), 32'd1);
        chk("reset_busy", 32'(bsy[0]), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            chk("idle_ser0", 32'(ser[0]), 32'd1);
            chk("idle_rdy0", 32'(rdy[0]), 32'd1);
            chk("idle_bsy0", 32'(bsy[0]), 32'd0);
            chk("idle_ser1", 32'(ser[1]), 32'd1);
        end

        // Single frame 8'hA5, 1 stop bit
        start(0, 8'hA5);
        frame(0, 8'hA5, 1'b0, 8'hA5, 1'b0);

        // Parity sense on both instances (even on 0, odd on 1)
        start(0, 8'h07);
        frame(0, 8'h07, 1'b0, 8'h07, 1'b0);
        start(1, 8'h07);
        frame(1, 8'h07, 1'b0, 8'h07, 1'b0);

        // Back-to-back with Valid held, 2 stop bits
        start(1, 8'h00);
        frame(1, 8'h00, 1'b1, 8'hFF, 1'b0);
        @(posedge clk);
        #1;
        frame(1, 8'hFF, 1'b0, 8'hFF, 1'b0);
        idle_check(1, 4 * CPB);

        // Din change after accept and a mid-frame Valid pulse are ignored
        start(0, 8'h5A);
        frame(0, 8'h5A, 1'b0, 8'hC3, 1'b1);
        idle_check(0, 4 * CPB);

        // Asynchronous reset during data bit 3, then a clean frame
        start(0, 8'h96);
        valid[0] = 1'b0;
        repeat (4 * CPB + 2) @(negedge clk);
        chk("pre_reset_bit3", 32'(ser[0]), 32'd0);
        chk("pre_reset_busy", 32'(bsy[0]), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_serout", 32'(ser[0]), 32'd1);
        chk("async_reset_ready", 32'(rdy[0]), 32'd1);
        chk("async_reset_busy", 32'(bsy[0]), 32'd0);
        din[0]   = 8'hFF;
        valid[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_wins_ready", 32'(rdy[0]), 32'd1);
        chk("reset_wins_serout", 32'(ser[0]), 32'd1);
        @(negedge clk);
        valid[0] = 1'b0;
        rst_n    = 1'b1;
        idle_check(0, 2);
        start(0, 8'h3C);
        frame(0, 8'h3C, 1'b0, 8'h3C, 1'b0);
        idle_check(0, 2 * CPB);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
